// File: rtl/fa_norm_lzc.sv
// -----------------------------------------------------------------------------
// fa_norm_lzc
// Leading-zero detect and normalization control for the FP add/sub datapath.
// Sits in front of the 25-bit left barrel shifter. It takes the raw significand
// sum and the pre-normalization exponent, and produces:
//   - the shift amount,
//   - the carry (shift right by 1) indication,
//   - the adjusted exponent,
//   - the zero and overflow flags.
// It is a two-stage valid/ready pipeline, so the adder and the shifter can stall
// independently of each other.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : upstream data valid
//   in_ready   : stage can accept an input this cycle (combinational)
//   mant_in    : significand sum [MW-1:0]; bit MW-1 = carry-out, MW-2 = hidden
//   exp_in     : pre-normalization biased exponent [EW-1:0]
//   sign_in    : result sign
//   out_valid  : outputs below are valid
//   out_ready  : downstream accepts
//   mant_out   : registered significand for the shifter
//   nshiftleft : left-shift amount 0..MW-1
//   shr1       : carry case, shift right by one instead of left
//   exp_out    : normalized exponent
//   sign_out   : registered sign
//   zero_out   : significand sum is zero
//   ovf_out    : exponent overflowed to infinity
// -----------------------------------------------------------------------------
module fa_norm_lzc #(
    parameter int MW   = 25,
    parameter int EW   = 8,
    parameter int EMAX = 254
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] mant_in,
    input  logic [EW-1:0] exp_in,
    input  logic          sign_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] mant_out,
    output logic [4:0]    nshiftleft,
    output logic          shr1,
    output logic [EW-1:0] exp_out,
    output logic          sign_out,
    output logic          zero_out,
    output logic          ovf_out
);

    localparam int            SW     = 5;
    localparam logic [EW:0]   L_EMAX = (EW+1)'(EMAX);
    localparam logic [EW:0]   L_ONE  = (EW+1)'(1);

    // Priority encode over the fraction field (carry bit excluded).
    // The highest set bit wins; an all-zero field returns MW-1.
    function automatic logic [SW-1:0] lzc(input logic [MW-2:0] m);
        logic [SW-1:0] cnt;
        cnt = SW'(MW-1);
        for (int i = 0; i < MW-1; i++) begin
            if (m[i]) cnt = SW'(MW-2-i);
        end
        return cnt;
    endfunction

    logic          r_vld_p1;
    logic [MW-1:0] r_mant_p1;
    logic [EW-1:0] r_exp_p1;
    logic          r_sign_p1;

    logic          r_vld_p2;
    logic [MW-1:0] r_mant_p2;
    logic [SW-1:0] r_nsl_p2;
    logic          r_shr1_p2;
    logic [EW-1:0] r_exp_p2;
    logic          r_sign_p2;
    logic          r_zero_p2;
    logic          r_ovf_p2;

    logic          w_adv2;
    logic          w_load1;
    logic          w_load2;
    logic [SW-1:0] w_lz;
    logic [EW:0]   w_e_ext;
    logic [EW:0]   w_lz_ext;
    logic [EW:0]   w_inc;
    logic [EW:0]   w_diff;
    logic [EW:0]   w_dm1;
    logic [SW-1:0] w_nsl;
    logic          w_shr1;
    logic [EW-1:0] w_exp;
    logic          w_zero;
    logic          w_ovf;
    logic          w_unused;

    assign w_adv2   = !r_vld_p2 || out_ready;
    assign in_ready = !r_vld_p1 || w_adv2;
    assign w_load1  = in_valid && in_ready;
    assign w_load2  = r_vld_p1 && w_adv2;

    // Exponent arithmetic is one bit wider than EW so that e+1 and e-lz never
    // wrap before the range checks select the result.
    assign w_lz     = lzc(r_mant_p1[MW-2:0]);
    assign w_e_ext  = {1'b0, r_exp_p1};
    assign w_lz_ext = {{(EW+1-SW){1'b0}}, w_lz};
    assign w_inc    = w_e_ext + L_ONE;
    assign w_diff   = w_e_ext - w_lz_ext;
    assign w_dm1    = w_e_ext - L_ONE;
    assign w_unused = &{1'b0, w_inc[EW], w_diff[EW], w_dm1[EW:SW]};

    always_comb begin
        w_nsl  = '0;
        w_shr1 = 1'b0;
        w_exp  = '0;
        w_zero = 1'b0;
        w_ovf  = 1'b0;
        if (r_mant_p1[MW-1]) begin
            w_shr1 = 1'b1;
            if (w_e_ext >= L_EMAX) begin
                w_exp = '1;
                w_ovf = 1'b1;
            end else begin
                w_exp = w_inc[EW-1:0];
            end
        end else if (r_mant_p1 == '0) begin
            w_zero = 1'b1;
        end else if (w_e_ext > w_lz_ext) begin
            w_nsl = w_lz;
            w_exp = w_diff[EW-1:0];
        end else if (r_exp_p1 != '0) begin
            // Shift only as far as the minimum exponent allows; the result
            // stays subnormal.
            w_nsl = w_dm1[SW-1:0];
        end
    end

    // ---- stage 1: capture operands ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_mant_p1 <= '0;
            r_exp_p1  <= '0;
            r_sign_p1 <= 1'b0;
        end else begin
            if (in_ready) r_vld_p1 <= in_valid;
            if (w_load1) begin
                r_mant_p1 <= mant_in;
                r_exp_p1  <= exp_in;
                r_sign_p1 <= sign_in;
            end
        end
    end

    // ---- stage 2: register normalization results ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_mant_p2 <= '0;
            r_nsl_p2  <= '0;
            r_shr1_p2 <= 1'b0;
            r_exp_p2  <= '0;
            r_sign_p2 <= 1'b0;
            r_zero_p2 <= 1'b0;
            r_ovf_p2  <= 1'b0;
        end else begin
            if (w_adv2) r_vld_p2 <= r_vld_p1;
            if (w_load2) begin
                r_mant_p2 <= r_mant_p1;
                r_nsl_p2  <= w_nsl;
                r_shr1_p2 <= w_shr1;
                r_exp_p2  <= w_exp;
                r_sign_p2 <= r_sign_p1;
                r_zero_p2 <= w_zero;
                r_ovf_p2  <= w_ovf;
            end
        end
    end

    assign out_valid  = r_vld_p2;
    assign mant_out   = r_mant_p2;
    assign nshiftleft = r_nsl_p2;
    assign shr1       = r_shr1_p2;
    assign exp_out    = r_exp_p2;
    assign sign_out   = r_sign_p2;
    assign zero_out   = r_zero_p2;
    assign ovf_out    = r_ovf_p2;

endmodule

// File: tb/tb_fa_norm_lzc.sv
module tb_fa_norm_lzc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] mant_in = '0;
    logic [7:0]  exp_in = '0;
    logic        sign_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] mant_out;
    logic [4:0]  nshiftleft;
    logic        shr1;
    logic [7:0]  exp_out;
    logic        sign_out;
    logic        zero_out;
    logic        ovf_out;

    fa_norm_lzc #(.MW(25), .EW(8), .EMAX(254)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mant_in(mant_in), .exp_in(exp_in), .sign_in(sign_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mant_out(mant_out), .nshiftleft(nshiftleft), .shr1(shr1),
        .exp_out(exp_out), .sign_out(sign_out),
        .zero_out(zero_out), .ovf_out(ovf_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] m;
        logic [7:0]  e;
        logic        s;
        logic [4:0]  nsl;
        logic        shr;
        logic [7:0]  ex;
        logic        z;
        logic        o;
    } vec_t;

    vec_t        tbl[12];
    logic [41:0] q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    bit          got_out;
    bit          last_acc;
    bit          last_in_ready;
    bit          stall_prev = 0;
    logic [42:0] snap;
    logic [41:0] last_res;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: floor(log2) of the fraction field by repeated halving.
    function automatic logic [41:0] model(input logic [24:0] m, input logic [7:0] e, input logic s);
        int lz, ei, nsl, ex, lg;
        bit shr, z, o;
        int unsigned v;
        nsl = 0; ex = 0; shr = 0; z = 0; o = 0; ei = int'(e);
        v = int'(m[23:0]);
        if (v == 0) lz = 24;
        else begin
            lg = 0;
            while (v > 1) begin v = v / 2; lg++; end
            lz = 23 - lg;
        end
        if (m[24]) begin
            shr = 1;
            if (ei >= 254) begin ex = 255; o = 1; end
            else ex = ei + 1;
        end else if (m == 0) begin
            z = 1;
        end else if (ei > lz) begin
            nsl = lz; ex = ei - lz;
        end else if (ei >= 1) begin
            nsl = ei - 1;
        end
        return {m, 5'(nsl), shr, 8'(ex), s, z, o};
    endfunction

    function automatic logic [41:0] pack_res();
        return {mant_out, nshiftleft, shr1, exp_out, sign_out, zero_out, ovf_out};
    endfunction

    // One clock cycle starting from a falling edge: drive, settle, score, advance.
    task automatic step(input logic v, input logic [24:0] m, input logic [7:0] e,
                        input logic s, input logic ordy);
        logic [41:0] exp_r;
        in_valid = v; mant_in = m; exp_in = e; sign_in = s; out_ready = ordy;
        #1;
        last_in_ready = in_ready;
        last_acc = in_valid && in_ready;
        got_out = 0;
        if (stall_prev)
            check("stall_hold", 64'({out_valid, pack_res()}), 64'(snap));
        if (out_valid && out_ready) begin
            got_out = 1;
            n_out++;
            last_res = pack_res();
            if (q.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'(0));
            end else begin
                exp_r = q.pop_front();
                check("result", 64'(last_res), 64'(exp_r));
            end
        end
        if (last_acc) q.push_back(model(m, e, s));
        stall_prev = out_valid && !out_ready;
        snap = {out_valid, pack_res()};
        @(negedge clk);
    endtask

    initial begin
        int k, idx, out0;
        bit saw_block;
        logic [24:0] rm;
        logic [7:0]  re;

        tbl[0]  = '{25'h0080000, 8'd100, 1'b0, 5'd4,  1'b0, 8'd96,  1'b0, 1'b0};
        tbl[1]  = '{25'h1800000, 8'd127, 1'b0, 5'd0,  1'b1, 8'd128, 1'b0, 1'b0};
        tbl[2]  = '{25'h1000000, 8'd254, 1'b1, 5'd0,  1'b1, 8'd255, 1'b0, 1'b1};
        tbl[3]  = '{25'h0000000, 8'd77,  1'b0, 5'd0,  1'b0, 8'd0,   1'b1, 1'b0};
        tbl[4]  = '{25'h0000001, 8'd5,   1'b0, 5'd4,  1'b0, 8'd0,   1'b0, 1'b0};
        tbl[5]  = '{25'h0FFFFFF, 8'd1,   1'b0, 5'd0,  1'b0, 8'd1,   1'b0, 1'b0};
        tbl[6]  = '{25'h0000001, 8'd24,  1'b0, 5'd23, 1'b0, 8'd1,   1'b0, 1'b0};
        tbl[7]  = '{25'h0000001, 8'd23,  1'b1, 5'd22, 1'b0, 8'd0,   1'b0, 1'b0};
        tbl[8]  = '{25'h0400000, 8'd0,   1'b0, 5'd0,  1'b0, 8'd0,   1'b0, 1'b0};
        tbl[9]  = '{25'h1FFFFFF, 8'd253, 1'b0, 5'd0,  1'b1, 8'd254, 1'b0, 1'b0};
        tbl[10] = '{25'h1000000, 8'd255, 1'b0, 5'd0,  1'b1, 8'd255, 1'b0, 1'b1};
        tbl[11] = '{25'h0000010, 8'd200, 1'b1, 5'd19, 1'b0, 8'd181, 1'b0, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", 64'({out_valid, pack_res()}), 64'(0));
        rst = 1'b0;
        #1 check("reset_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Directed vectors, one at a time, latency checked
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].m, tbl[i].e, tbl[i].s, 1'b1);
            k = 0;
            got_out = 0;
            while (!got_out && k < 6) begin
                k++;
                step(1'b0, 25'h0, 8'h0, 1'b0, 1'b1);
            end
            check("latency", 64'(k), 64'(2));
            check("vector", 64'(last_res),
                  64'({tbl[i].m, tbl[i].nsl, tbl[i].shr, tbl[i].ex, tbl[i].s, tbl[i].z, tbl[i].o}));
        end

        // Back-pressure: six inputs, out_ready low on cycles 3..6
        idx = 0; saw_block = 0; out0 = n_out;
        for (int c = 1; c <= 20; c++) begin
            rm = 25'(idx + 1) << (3 * (idx + 1));
            re = 8'(50 + idx);
            step(idx < 6, rm, re, 1'(idx), !(c >= 3 && c <= 6));
            if (idx < 6 && !last_in_ready) saw_block = 1;
            if (last_acc) idx++;
        end
        check("bp_in_ready_fell", 64'(saw_block), 64'(1));
        check("bp_output_count", 64'(n_out - out0), 64'(6));
        check("bp_queue_empty", 64'(q.size()), 64'(0));

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rm = 25'($urandom) >> $urandom_range(0, 25);
            case ($urandom_range(0, 2))
                0: re = 8'($urandom_range(0, 30));
                1: re = 8'($urandom_range(240, 255));
                default: re = 8'($urandom);
            endcase
            step(1'($urandom_range(0, 3) != 0), rm, re, 1'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int c = 0; c < 10; c++) step(1'b0, 25'h0, 8'h0, 1'b0, 1'b1);
        check("rand_drained", 64'(q.size()), 64'(0));

        // Asynchronous reset with both stages full
        step(1'b1, 25'h0123456, 8'd90, 1'b0, 1'b0);
        step(1'b1, 25'h0654321, 8'd91, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_in_ready", 64'(in_ready), 64'(1));
        q.delete();
        stall_prev = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 25'h0002000, 8'd60, 1'b1, 1'b1);
        check("post_rst_accept", 64'(last_acc), 64'(1));
        k = 0;
        got_out = 0;
        while (!got_out && k < 6) begin
            k++;
            step(1'b0, 25'h0, 8'h0, 1'b0, 1'b1);
        end
        check("post_rst_latency", 64'(k), 64'(2));
        check("post_rst_queue", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
